ldpc_circ_addr_gen: RTL
=======================

Name: ldpc_circ_addr_gen

Overview:
- Multi-lane address generator for circulant-based LDPC memory access; successor to the plain enable/reset counter.
- For each circulant block it emits the Z addresses base + ((shift + j) mod z), for j = 0 .. z-1, LANES addresses per beat.
- Uses a valid/ready handshake with start/done control and config checking.
- Sits between the layer scheduler (drives start/base/z/shift) and the VN/CN memory banks (consume addr/lane_vld).

Parameters:
- ADDR_W, 8, width of base and of every output address.
- Z_W, 8, width of z and shift; maximum circulant size is 2^Z_W - 1.
- LANES, 1, addresses produced per beat; must be 1..2^Z_W - 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset; clock clk.
- start  in  1  request a new sequence; sampled only when busy=0.
- base  in  ADDR_W  block base address, latched on accepted start.
- z  in  Z_W  circulant size, latched on accepted start.
- shift  in  Z_W  circulant shift, latched on accepted start.
- ready  in  1  downstream accepts the current beat.
- valid  out  1  beat present on addr/lane_vld.
- addr  out  LANES*ADDR_W  lane l occupies bits [l*ADDR_W +: ADDR_W].
- lane_vld  out  LANES  per-lane qualifier; 1 when index j < z.
- last  out  1  final beat of the sequence.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse after the final handshake.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- FSM has two states, IDLE and RUN. Reset forces IDLE, and all outputs (valid, addr, lane_vld, last, busy, done, cfg_err) go to 0.
- IDLE with start=1 checks the config. If z==0, or shift>=z, or z<LANES: assert cfg_err for 1 cycle and stay in IDLE. Otherwise latch base/z/shift and enter RUN.
- Latency: a start accepted at edge t gives valid=1, busy=1 and beat 0 from cycle t+1.
- In RUN, beat k lane l uses index j = k*LANES + l and offset off = (shift + j) mod z. addr_l = (base + off) truncated to ADDR_W, so address wrap at 2^ADDR_W is permitted and silent.
- No divider. Each lane keeps its offset register. Per beat add LANES, and if the result is >= z subtract z. This is one compare/subtract, valid because LANES <= z.
- lane_vld[l] = (j < z). Lanes with j >= z on the final beat present don't-care addresses.
- Number of beats = ceil(z/LANES). last=1 exactly on the final beat.
- The beat advances only on valid && ready. When ready=0, addr/lane_vld/last hold stable.
- On the final handshake, go to IDLE: valid=0 and busy=0 next cycle, with done=1 for that one cycle.
- start while busy=1 is ignored, with no error. A start in the same cycle as done (already IDLE) is accepted normally.
- reset in RUN aborts immediately: IDLE, no done pulse.
- Back-to-back: after done, a new start gives a one-cycle IDLE gap minimum.

Optional Feature:
- Macro: LDPC_ADDR_GEN_DOWN_EN.
- When defined, adds input dir (1 bit, latched on start).
  - dir=1 gives a descending sequence, off = (shift - j) mod z.
  - Each lane steps by -LANES, adding z on underflow.
  - dir=0 behaves identically to the undefined build.
- When undefined: no dir port, ascending only.

Decomposition:
- Package ldpc_addr_pkg holds the FSM state enum (ST_IDLE, ST_RUN) and the default ADDR_W/Z_W constants shared with the scheduler.
- One natural sub-module, ldpc_mod_step: a combinational modular step that takes off, step, z (and dir when enabled) and returns the next off.
- Instantiate ldpc_mod_step once per lane, via a generate loop.

Test Plan:
- LANES=1, base=0x10, z=5, shift=2, ready=1: addrs 0x12,0x13,0x14,0x10,0x11; last on beat 4; done 1 cycle later.
- LANES=4, z=6, shift=5, base=0: beat0 {5,0,1,2} lane_vld=1111; beat1 {3,4,x,x} lane_vld=0011 with last=1.
- Backpressure: z=4, ready toggled 1,0,0,1,...: each address is held while ready=0, no beat is skipped or duplicated, and exactly 4 handshakes occur.
- Config errors: z=0, then z=3 shift=3, then LANES=4 z=2: each gives a cfg_err pulse with busy staying 0. start during RUN is ignored.
- Reset mid-RUN after 2 beats: next cycle valid=busy=0 with no done. A fresh start=1 z=3 shift=0 gives 0,1,2.
- LDPC_ADDR_GEN_DOWN_EN, dir=1, z=5, shift=1, base=0: addrs 1,0,4,3,2; base=0xFE z=4 shift=3 dir=0 gives wrap to 0x01,0xFE,0xFF,0x00.

Source files
------------

// File: rtl/ldpc_addr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ldpc_addr_pkg
//  Purpose  : Shared types and default widths for the LDPC circulant address
//             generator and the layer scheduler that drives it.
//  Revision : 1.0 - initial release
// ============================================================================
package ldpc_addr_pkg;

  // Default widths shared with the layer scheduler
  localparam int LDPC_ADDR_W = 8;
  localparam int LDPC_Z_W    = 8;

  // Generator control states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage : ldpc_addr_pkg
`default_nettype wire

// File: rtl/ldpc_mod_step.sv
`default_nettype none
// ============================================================================
//  Module   : ldpc_mod_step
//  Purpose  : Combinational modular step of one lane offset: off +/- step
//             folded back into [0, z) with a single compare and correction.
//             Requires off < z and step <= z.
//  Options  : LDPC_ADDR_GEN_DOWN_EN adds i_dir (1 = descending step).
//  Revision : 1.0 - initial release
// ============================================================================
module ldpc_mod_step #(
  parameter int Z_W = 8
) (
  input  logic [Z_W-1:0] i_off,
  input  logic [Z_W-1:0] i_step,
  input  logic [Z_W-1:0] i_z,
`ifdef LDPC_ADDR_GEN_DOWN_EN
  input  logic           i_dir,
`endif
  output logic [Z_W-1:0] o_off
);

  // Overflow past z (ascending) is judged with one extra bit so the sum
  // cannot alias; the correction itself is done modulo 2^Z_W because the
  // true result always lies below z.
  logic w_up_wrap;
  assign w_up_wrap = ({1'b0, i_off} + {1'b0, i_step}) >= {1'b0, i_z};

  // Select the folded next offset for the active direction
  always_comb begin
    o_off = i_off + i_step - (w_up_wrap ? i_z : '0);
`ifdef LDPC_ADDR_GEN_DOWN_EN
    if (i_dir) begin
      o_off = i_off - i_step + ((i_off < i_step) ? i_z : '0);
    end
`endif
  end

endmodule : ldpc_mod_step
`default_nettype wire

// File: rtl/ldpc_circ_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ldpc_circ_addr_gen
//  Purpose  : Multi-lane circulant address generator. For an accepted block
//             it emits base + ((shift + j) mod z), j = 0..z-1, LANES per beat,
//             over a valid/ready handshake with start/done/cfg_err control.
//  Options  : LDPC_ADDR_GEN_DOWN_EN adds i_dir (latched on start); dir=1
//             gives the descending sequence base + ((shift - j) mod z).
//  Revision : 1.0 - initial release
// ============================================================================
module ldpc_circ_addr_gen
  import ldpc_addr_pkg::*;
#(
  parameter int ADDR_W = LDPC_ADDR_W,
  parameter int Z_W    = LDPC_Z_W,
  parameter int LANES  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic [ADDR_W-1:0]       i_base,
  input  logic [Z_W-1:0]          i_z,
  input  logic [Z_W-1:0]          i_shift,
`ifdef LDPC_ADDR_GEN_DOWN_EN
  input  logic                    i_dir,
`endif
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [LANES*ADDR_W-1:0] o_addr,
  output logic [LANES-1:0]        o_lane_vld,
  output logic                    o_last,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_cfg_err
);

  localparam logic [Z_W-1:0] c_STEP  = Z_W'(LANES);
  localparam logic [Z_W:0]   c_LANES = (Z_W+1)'(LANES);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [Z_W-1:0]  r_z;
  logic [Z_W:0]    r_jbase;     // index j of lane 0 in the current beat
  logic            r_done;
  logic            r_cfg_err;
  logic            w_dir;

  logic            w_cfg_ok;
  logic            w_is_last;
  logic            w_accept;
  logic            w_reject;
  logic            w_fire;
  logic            w_final;

`ifdef LDPC_ADDR_GEN_DOWN_EN
  logic            r_dir;

  // Direction is captured with the rest of the block configuration
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dir <= 1'b0;
    end else if (w_accept) begin
      r_dir <= i_dir;
    end
  end

  assign w_dir = i_dir;
`else
  assign w_dir = 1'b0;
`endif

  // A block is legal when it is non-empty, the shift lies inside it and
  // every lane of the first beat maps to a distinct index (z >= LANES),
  // which is also what keeps the per-beat step a single correction.
  assign w_cfg_ok  = (i_z != '0) && (i_shift < i_z) && ({1'b0, i_z} >= c_LANES);
  assign w_is_last = (r_jbase + c_LANES) >= {1'b0, r_z};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and handshake qualification
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_fire      = 1'b0;
    w_final     = 1'b0;
    o_valid     = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (w_cfg_ok) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_reject    = 1'b1;
          end
        end
      end
      ST_RUN: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
        if (i_ready) begin
          w_fire = 1'b1;
          if (w_is_last) begin
            w_final     = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Block configuration, beat index and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base    <= '0;
      r_z       <= '0;
      r_jbase   <= '0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_done    <= w_final;
      r_cfg_err <= w_reject;
      if (w_accept) begin
        r_base  <= i_base;
        r_z     <= i_z;
        r_jbase <= '0;
      end else if (w_fire) begin
        r_jbase <= r_jbase + c_LANES;
      end
    end
  end

  assign o_last    = (r_state == ST_RUN) && w_is_last;
  assign o_done    = r_done;
  assign o_cfg_err = r_cfg_err;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam logic [Z_W-1:0] c_IDX = Z_W'(l);

    logic [Z_W-1:0] r_off;
    logic [Z_W-1:0] w_off_nxt;
    logic [Z_W-1:0] w_init_off;
    logic           w_init_wrap;

    assign w_init_wrap = ({1'b0, i_shift} + {1'b0, c_IDX}) >= {1'b0, i_z};

    // Starting offset of this lane: (shift +/- l) mod z, valid since l < z
    always_comb begin
      w_init_off = i_shift + c_IDX - (w_init_wrap ? i_z : '0);
      if (w_dir) begin
        w_init_off = i_shift - c_IDX + ((i_shift < c_IDX) ? i_z : '0);
      end
    end

    ldpc_mod_step #(
      .Z_W    (Z_W)
    ) u_step (
      .i_off  (r_off),
      .i_step (c_STEP),
      .i_z    (r_z),
`ifdef LDPC_ADDR_GEN_DOWN_EN
      .i_dir  (r_dir),
`endif
      .o_off  (w_off_nxt)
    );

    // Offset advances only on a handshake so the address holds under stall
    always_ff @(posedge clk) begin
      if (reset) begin
        r_off <= '0;
      end else if (w_accept) begin
        r_off <= w_init_off;
      end else if (w_fire) begin
        r_off <= w_off_nxt;
      end
    end

    assign o_addr[l*ADDR_W +: ADDR_W] = r_base + ADDR_W'(r_off);
    assign o_lane_vld[l] = (r_state == ST_RUN) &&
                           ((r_jbase + {1'b0, c_IDX}) < {1'b0, r_z});
  end : g_lane

endmodule : ldpc_circ_addr_gen
`default_nettype wire
